uart_tx_arbiter: RTL and testbench

- Shares one uart transmit channel (its write-side FIFO interface: write strobe, data byte, tx_full) between two byte-stream requesters.
- Arbitration is packet-locked and round-robin. Each granted packet is optionally prefixed with a requester header byte.
- A per-grant byte limit enforces fairness: a long packet is split and the other requester is serviced in between.
- Sits between system-level producers and the uart instance's wr_uart/w_data/tx_full pins.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester, packet-locked round-robin arbiter in front of a uart TX FIFO write port.
// Each grant optionally starts with a requester header byte; grants are capped at MAX_BYTES data bytes.
module uart_tx_arbiter #(
  parameter int          ADD_HEADER = 1,
  parameter logic [7:0]  HDR0       = 8'hA0,
  parameter logic [7:0]  HDR1       = 8'hB0,
  parameter int unsigned MAX_BYTES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       uart_tx_full,
  output logic       uart_wr,
  output logic [7:0] uart_wdata,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       busy_q, busy_d;

  logic       owner;
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;
  logic       xfer;
  logic [7:0] cnt_inc;
  logic       pick;

  // Owner index is grant_q[1]: 2'b01 -> requester 0, 2'b10 -> requester 1.
  assign owner   = grant_q[1];
  assign cnt_inc = byte_cnt_q + 8'd1;

  always_comb begin
    own_valid = owner ? req1_valid : req0_valid;
    own_last  = owner ? req1_last  : req0_last;
    own_data  = owner ? req1_data  : req0_data;
  end

  assign xfer = (state_q == DATA) && own_valid && !uart_tx_full;

  always_comb begin
    uart_wr    = 1'b0;
    uart_wdata = 8'h00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      HDR: begin
        uart_wr    = !uart_tx_full;
        uart_wdata = uart_tx_full ? 8'h00 : (owner ? HDR1 : HDR0);
      end
      DATA: begin
        req0_ready = !owner && !uart_tx_full;
        req1_ready = owner && !uart_tx_full;
        uart_wr    = xfer;
        uart_wdata = xfer ? own_data : 8'h00;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    // Only the pointer decides a tie; a lone requester wins regardless of it.
    pick       = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d    = pick ? 2'b10 : 2'b01;
          state_d    = (ADD_HEADER != 0) ? HDR : DATA;
          byte_cnt_d = 8'd0;
        end
      end
      HDR: begin
        if (!uart_tx_full) state_d = DATA;
      end
      DATA: begin
        if (xfer) begin
          byte_cnt_d = cnt_inc;
          if (own_last || (cnt_inc == MAX_CNT)) begin
            state_d  = IDLE;
            grant_d  = 2'b00;
            rr_ptr_d = !owner;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      rr_ptr_q   <= 1'b0;
      byte_cnt_q <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default, MAX_BYTES=4 and no-header instances.
module tb_uart_tx_arbiter;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       v0[3], l0[3], v1[3], l1[3], full[3];
  logic [7:0] d0[3], d1[3];
  logic       rdy0[3], rdy1[3], wr[3], bsy[3];
  logic [7:0] wd[3];
  logic [1:0] gnt[3];

  uart_tx_arbiter dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_last(l0[0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_last(l1[0]), .req1_ready(rdy1[0]),
    .uart_tx_full(full[0]), .uart_wr(wr[0]), .uart_wdata(wd[0]), .grant(gnt[0]), .busy(bsy[0])
  );

  uart_tx_arbiter #(.MAX_BYTES(4)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_last(l0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_last(l1[1]), .req1_ready(rdy1[1]),
    .uart_tx_full(full[1]), .uart_wr(wr[1]), .uart_wdata(wd[1]), .grant(gnt[1]), .busy(bsy[1])
  );

  uart_tx_arbiter #(.ADD_HEADER(0)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[2]), .req0_data(d0[2]), .req0_last(l0[2]), .req0_ready(rdy0[2]),
    .req1_valid(v1[2]), .req1_data(d1[2]), .req1_last(l1[2]), .req1_ready(rdy1[2]),
    .uart_tx_full(full[2]), .uart_wr(wr[2]), .uart_wdata(wd[2]), .grant(gnt[2]), .busy(bsy[2])
  );

  int passed = 0;
  int total  = 0;
  int sel    = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       fs[$];
  logic [7:0] wq[$];
  int         wcyc[$];
  logic [1:0] glog[64];
  logic       blog[64];
  int         proto_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      v0[k] = 1'b0; d0[k] = 8'h00; l0[k] = 1'b0;
      v1[k] = 1'b0; d1[k] = 8'h00; l1[k] = 1'b0;
      full[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); fs.delete();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Cycle-stepped driver/monitor on instance sel; stops when drained and idle, or after stop_w writes.
  task automatic run(input int maxc, input int stop_w);
    int  c    = 0;
    bit  done = 0;
    logic f;
    wq.delete(); wcyc.delete(); proto_bad = 0;
    for (int k = 0; k < 64; k++) begin glog[k] = 2'b00; blog[k] = 1'b0; end
    while (!done && c < maxc) begin
      @(negedge clk);
      clear_inputs();
      if (q0.size() > 0) begin v0[sel] = 1'b1; d0[sel] = q0[0][7:0]; l0[sel] = q0[0][8]; end
      if (q1.size() > 0) begin v1[sel] = 1'b1; d1[sel] = q1[0][7:0]; l1[sel] = q1[0][8]; end
      f = (fs.size() > 0) ? fs.pop_front() : 1'b0;
      full[sel] = f;
      #1;
      if (wr[sel]) begin wq.push_back(wd[sel]); wcyc.push_back(c); end
      if (wr[sel] && f) proto_bad++;
      if (rdy0[sel] && (gnt[sel] != 2'b01 || f)) proto_bad++;
      if (rdy1[sel] && (gnt[sel] != 2'b10 || f)) proto_bad++;
      glog[c] = gnt[sel];
      blog[c] = bsy[sel];
      if (v0[sel] && rdy0[sel]) void'(q0.pop_front());
      if (v1[sel] && rdy1[sel]) void'(q1.pop_front());
      c++;
      if (q0.size() == 0 && q1.size() == 0 && !bsy[sel]) done = 1;
      if (stop_w > 0 && wq.size() >= stop_w) done = 1;
    end
    chk("finished_in_budget", 32'(done), 32'd1);
    chk("protocol", 32'(proto_bad), 32'd0);
  endtask

  task automatic cmp_seq(input string tag, input bq_t e);
    chk({tag, "_len"}, 32'(wq.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, 32'(e[i]));
  endtask

  initial begin
    sel = 0;
    do_reset();
    #1;
    chk("rst_wr", 32'(wr[0]), 32'd0);
    chk("rst_wdata", 32'(wd[0]), 32'd0);
    chk("rst_grant", 32'(gnt[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_ready0", 32'(rdy0[0]), 32'd0);
    chk("rst_ready1", 32'(rdy1[0]), 32'd0);

    // Single 3-byte packet, no backpressure.
    q0 = '{9'h011, 9'h022, 9'h133};
    run(40, 0);
    cmp_seq("t1", '{8'hA0, 8'h11, 8'h22, 8'h33});
    chk("t1_cyc_hdr", 32'(wcyc[0]), 32'd1);
    chk("t1_cyc_last", 32'(wcyc[3]), 32'd4);
    chk("t1_grant_mid", 32'(glog[2]), 32'h1);
    chk("t1_busy_at_last", 32'(blog[4]), 32'd1);
    chk("t1_busy_after", 32'(blog[5]), 32'd0);
    chk("t1_grant_after", 32'(glog[5]), 32'd0);

    // Contention from reset: requester 0 first, then requester 1, twice.
    do_reset();
    q0 = '{9'h051, 9'h152};
    q1 = '{9'h061, 9'h162};
    run(40, 0);
    cmp_seq("t2a", '{8'hA0, 8'h51, 8'h52, 8'hB0, 8'h61, 8'h62});
    chk("t2a_grant_r1", 32'(glog[5]), 32'h2);
    q0 = '{9'h053, 9'h154};
    q1 = '{9'h063, 9'h164};
    run(40, 0);
    cmp_seq("t2b", '{8'hA0, 8'h53, 8'h54, 8'hB0, 8'h63, 8'h64});

    // Backpressure: full for 5 cycles in HDR and 5 cycles on byte 2.
    do_reset();
    q0 = '{9'h011, 9'h022, 9'h133};
    fs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run(40, 0);
    cmp_seq("t3", '{8'hA0, 8'h11, 8'h22, 8'h33});
    chk("t3_cyc0", 32'(wcyc[0]), 32'd6);
    chk("t3_cyc1", 32'(wcyc[1]), 32'd7);
    chk("t3_cyc2", 32'(wcyc[2]), 32'd13);
    chk("t3_cyc3", 32'(wcyc[3]), 32'd14);

    // Reset mid-packet (rr pointer currently points at requester 1).
    q0 = '{9'h0E1, 9'h0E2, 9'h0E3, 9'h0E4, 9'h1E5};
    run(40, 3);
    cmp_seq("t6_pre", '{8'hA0, 8'hE1, 8'hE2});
    @(posedge clk);
    #2;
    chk("t6_grant_before", 32'(gnt[0]), 32'h1);
    chk("t6_busy_before", 32'(bsy[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_grant", 32'(gnt[0]), 32'd0);
    chk("t6_async_busy", 32'(bsy[0]), 32'd0);
    chk("t6_async_wr", 32'(wr[0]), 32'd0);
    chk("t6_async_ready0", 32'(rdy0[0]), 32'd0);
    q0.delete(); q1.delete(); fs.delete();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    q0 = '{9'h171};
    q1 = '{9'h181};
    run(40, 0);
    cmp_seq("t6_post", '{8'hA0, 8'h71, 8'hB0, 8'h81});

    // Byte limit of 4 splits a 6-byte packet around requester 1.
    sel = 1;
    do_reset();
    q0 = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4, 9'h1C5};
    q1 = '{9'h1D0};
    run(60, 0);
    cmp_seq("t4", '{8'hA0, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hB0, 8'hD0, 8'hA0, 8'hC4, 8'hC5});

    // No header: single one-byte packet.
    sel = 2;
    do_reset();
    q0 = '{9'h15A};
    run(20, 0);
    cmp_seq("t5", '{8'h5A});
    chk("t5_cyc", 32'(wcyc[0]), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
